// File: rtl/amplitude_ramp_pkg.sv
// Shared definitions for the amplitude ramp generator: default widths and FSM state encoding.
package amplitude_ramp_pkg;

   localparam int DEFAULT_DATA_WIDTH     = 16;
   localparam int DEFAULT_INTERVAL_WIDTH = 16;

   // IDLE accepts commands; RAMP slews the amplitude towards the latched target.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } ramp_state_t;

endpackage

// File: rtl/amplitude_ramp_interval_tick.sv
// Loadable down-counter pacing the ramp: tick fires while enabled and the count sits at zero.
module interval_tick #(
   parameter int INTERVAL_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      load,
   input  logic [INTERVAL_WIDTH-1:0] load_val,
   output logic                      tick
);

   logic [INTERVAL_WIDTH-1:0] count_reg;

   assign tick = en & (count_reg == '0);

   // Load has priority; otherwise count down while enabled, parking at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - INTERVAL_WIDTH'(1);
      end
   end

endmodule

// File: rtl/amplitude_ramp.sv
// Amplitude ramp generator: slews a signed amplitude linearly to a commanded target,
// one step per interval, and pulses done when the target is reached.
module amplitude_ramp
   import amplitude_ramp_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int INTERVAL_WIDTH = DEFAULT_INTERVAL_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] cmd_target,
   input  logic        [DATA_WIDTH-1:0] cmd_step,
   input  logic    [INTERVAL_WIDTH-1:0] cmd_interval,
   input  logic                         cmd_tvalid,
   output logic                         cmd_tready,
   input  logic                         halt,
   output logic signed [DATA_WIDTH-1:0] amplitude,
   output logic                         busy,
   output logic                         done
);

   ramp_state_t                  state_reg;
   logic signed [DATA_WIDTH-1:0] amplitude_reg;
   logic signed [DATA_WIDTH-1:0] target_reg;
   logic        [DATA_WIDTH-1:0] step_reg;
   logic    [INTERVAL_WIDTH-1:0] interval_reg;
   logic                         busy_reg;
   logic                         done_reg;

   logic                         accept;
   logic                         in_ramp;
   logic                         tick;
   logic                         cnt_load;
   logic    [INTERVAL_WIDTH-1:0] cnt_load_val;
   logic signed   [DATA_WIDTH:0] diff;
   logic          [DATA_WIDTH:0] diff_mag;
   logic                         reach;
   logic        [DATA_WIDTH-1:0] stepped_next;

   assign cmd_tready = (state_reg == ST_IDLE) & ~reset;
   assign accept     = cmd_tvalid & cmd_tready;
   assign in_ramp    = (state_reg == ST_RAMP);
   assign amplitude  = amplitude_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;

   // Counter restarts from zero on accept or halt so the first tick is the cycle after accept;
   // a non-final tick reloads the interval.
   assign cnt_load     = accept | (in_ramp & (halt | tick));
   assign cnt_load_val = (in_ramp & ~halt & tick & ~reach) ? interval_reg : '0;

   interval_tick #(
      .INTERVAL_WIDTH (INTERVAL_WIDTH)
   ) u_interval_tick (
      .clk      (clk),
      .reset    (reset),
      .en       (in_ramp),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .tick     (tick)
   );

   // Distance to target in one extra bit so full-scale swings cannot wrap; the step
   // is applied only when strictly smaller than that distance, so the result never overshoots.
   always_comb begin
      diff     = {target_reg[DATA_WIDTH-1], target_reg} - {amplitude_reg[DATA_WIDTH-1], amplitude_reg};
      diff_mag = diff[DATA_WIDTH] ? (-diff) : diff;
      reach    = (step_reg == '0) | (diff_mag <= {1'b0, step_reg});
      if (diff[DATA_WIDTH]) begin
         stepped_next = amplitude_reg - step_reg;
      end else begin
         stepped_next = amplitude_reg + step_reg;
      end
   end

   // Ramp FSM with registered amplitude, busy and done; halt overrides a coincident tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         amplitude_reg <= '0;
         target_reg    <= '0;
         step_reg      <= '0;
         interval_reg  <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  target_reg   <= cmd_target;
                  step_reg     <= cmd_step;
                  interval_reg <= cmd_interval;
                  busy_reg     <= 1'b1;
                  state_reg    <= ST_RAMP;
               end
            end
            ST_RAMP: begin
               if (halt) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (tick) begin
                  if (reach) begin
                     amplitude_reg <= target_reg;
                     done_reg      <= 1'b1;
                     busy_reg      <= 1'b0;
                     state_reg     <= ST_IDLE;
                  end else begin
                     amplitude_reg <= stepped_next;
                  end
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
